// File: rtl/seq_pattern_gen_if.sv
// Pattern-offer channel of seq_pattern_gen: a parallel pattern plus its repeat count.
// A pattern moves on a posedge where in_valid and in_ready are both 1; in_data/in_rep matter only then.
interface seq_pattern_gen_if #(
  parameter int WIDTH = 8,
  parameter int REP_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [REP_W-1:0] in_rep;

  modport master (output in_valid, output in_data, output in_rep, input in_ready);
  modport slave  (input in_valid, input in_data, input in_rep, output in_ready);
endinterface

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: sends an accepted WIDTH-bit pattern MSB-first,
// (1 + in_rep) times, with GAP_CYCLES idle cycles after every copy.
module seq_pattern_gen #(
  parameter int WIDTH      = 8,
  parameter int REP_W      = 4,
  parameter int GAP_CYCLES = 2,
  parameter bit IDLE_BIT   = 1'b0
) (
  input  logic                    clk,
  input  logic                    clr,
  seq_pattern_gen_if.slave        in_bus,
  input  logic                    abort,
  output logic                    x,
  output logic                    x_en,
  output logic                    busy,
  output logic                    done,
  output logic [1:0]              state_dbg
);

  localparam int BW       = $clog2(WIDTH);
  localparam int GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [BW-1:0] BIT_MAX = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_MAX = GW'(GAP_LOAD);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [BW-1:0]      bit_q, bit_d;
  logic [REP_W-1:0]   rep_q, rep_d;
  logic [GW-1:0]      gap_q, gap_d;
  logic               done_q, done_d;
  logic               in_ready;

  assign in_ready        = (state_q == S_IDLE) && !abort;
  assign in_bus.in_ready = in_ready;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      bit_q   <= '0;
      rep_q   <= '0;
      gap_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      rep_q   <= rep_d;
      gap_q   <= gap_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    rep_d   = rep_q;
    gap_d   = gap_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (in_bus.in_valid && in_ready) begin
          shreg_d = in_bus.in_data;
          bit_d   = BIT_MAX;
          rep_d   = in_bus.in_rep;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          // Rotating (not shifting) leaves the original pattern in place for the next copy.
          shreg_d = {shreg_q[WIDTH-2:0], shreg_q[WIDTH-1]};
          if (bit_q != '0) begin
            bit_d = bit_q - 1'b1;
          end else if (GAP_CYCLES > 0) begin
            gap_d   = GAP_MAX;
            state_d = S_GAP;
          end else if (rep_q != '0) begin
            rep_d = rep_q - 1'b1;
            bit_d = BIT_MAX;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (gap_q != '0) begin
          gap_d = gap_q - 1'b1;
        end else if (rep_q != '0) begin
          rep_d   = rep_q - 1'b1;
          bit_d   = BIT_MAX;
          state_d = S_SHIFT;
        end else begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign x         = (state_q == S_SHIFT) ? shreg_q[WIDTH-1] : IDLE_BIT;
  assign x_en      = (state_q == S_SHIFT);
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Bench for seq_pattern_gen: a GAP_CYCLES=2 instance (a) and a GAP_CYCLES=0 instance (b)
// share clk/clr/data/abort; each transfer is checked cycle by cycle against a queue model.
module tb_seq_pattern_gen;

  localparam int W = 8;
  localparam int R = 4;

  logic clk = 1'b0;
  logic clr;
  logic iv_a, iv_b;
  logic [W-1:0] din;
  logic [R-1:0] drep;
  logic abort;

  logic x_a, xen_a, busy_a, done_a, x_b, xen_b, busy_b, done_b;
  logic [1:0] st_a, st_b;

  seq_pattern_gen_if #(.WIDTH(W), .REP_W(R)) bus_a ();
  seq_pattern_gen_if #(.WIDTH(W), .REP_W(R)) bus_b ();

  assign bus_a.in_valid = iv_a;
  assign bus_a.in_data  = din;
  assign bus_a.in_rep   = drep;
  assign bus_b.in_valid = iv_b;
  assign bus_b.in_data  = din;
  assign bus_b.in_rep   = drep;

  seq_pattern_gen #(.WIDTH(W), .REP_W(R), .GAP_CYCLES(2), .IDLE_BIT(1'b0)) dut_a (
    .clk(clk), .clr(clr), .in_bus(bus_a), .abort(abort),
    .x(x_a), .x_en(xen_a), .busy(busy_a), .done(done_a), .state_dbg(st_a)
  );

  seq_pattern_gen #(.WIDTH(W), .REP_W(R), .GAP_CYCLES(0), .IDLE_BIT(1'b0)) dut_b (
    .clk(clk), .clr(clr), .in_bus(bus_b), .abort(abort),
    .x(x_b), .x_en(xen_b), .busy(busy_b), .done(done_b), .state_dbg(st_b)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  bit cur_sel = 1'b0;
  logic [1:0] exp_q[$];

  logic o_x, o_xen, o_busy, o_done, o_rdy;
  always_comb begin
    o_x    = cur_sel ? x_b    : x_a;
    o_xen  = cur_sel ? xen_b  : xen_a;
    o_busy = cur_sel ? busy_b : busy_a;
    o_done = cur_sel ? done_b : done_a;
    o_rdy  = cur_sel ? bus_b.in_ready : bus_a.in_ready;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_valid(input bit v);
    if (cur_sel) iv_b = v; else iv_a = v;
  endtask

  task automatic idle_chk(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      step();
      chk($sformatf("%s idle busy", tag), o_busy, 1'b0);
      chk($sformatf("%s idle done", tag), o_done, 1'b0);
      chk($sformatf("%s idle x_en", tag), o_xen, 1'b0);
    end
  endtask

  // One transfer, starting from an idle cycle. abort_at=0 means run to completion,
  // ending in the done cycle; otherwise abort is raised in that cycle and the task ends
  // in the following idle cycle with abort released.
  task automatic xfer(input bit sel, input logic [W-1:0] d, input logic [R-1:0] r,
                      input int abort_at, input bit hold, input string tag);
    int gap;
    int len;
    logic [1:0] e;
    cur_sel = sel;
    gap = sel ? 0 : 2;
    exp_q.delete();
    for (int c = 0; c <= int'(r); c++) begin
      for (int b = W - 1; b >= 0; b--) exp_q.push_back({1'b1, d[b]});
      for (int g = 0; g < gap; g++) exp_q.push_back(2'b00);
    end
    len = exp_q.size();
    #0;
    chk({tag, " ready@accept"}, o_rdy, 1'b1);
    set_valid(1'b1);
    din  = d;
    drep = r;
    for (int k = 1; k <= len; k++) begin
      step();
      if (k == 1) begin
        set_valid(hold);
        din  = W'($urandom);
        drep = R'($urandom);
      end
      e = exp_q.pop_front();
      chk($sformatf("%s c%0d x_en", tag, k), o_xen, e[1]);
      chk($sformatf("%s c%0d x", tag, k), o_x, e[0]);
      chk($sformatf("%s c%0d busy", tag, k), o_busy, 1'b1);
      chk($sformatf("%s c%0d done", tag, k), o_done, 1'b0);
      chk($sformatf("%s c%0d ready", tag, k), o_rdy, 1'b0);
      if (k == abort_at) begin
        abort = 1'b1;
        step();
        chk($sformatf("%s abort x_en", tag), o_xen, 1'b0);
        chk($sformatf("%s abort x", tag), o_x, 1'b0);
        chk($sformatf("%s abort busy", tag), o_busy, 1'b0);
        chk($sformatf("%s abort done", tag), o_done, 1'b0);
        abort = 1'b0;
        set_valid(1'b0);
        #1;
        chk($sformatf("%s abort ready", tag), o_rdy, 1'b1);
        return;
      end
    end
    step();
    chk($sformatf("%s done pulse", tag), o_done, 1'b1);
    chk($sformatf("%s done busy", tag), o_busy, 1'b0);
    chk($sformatf("%s done x_en", tag), o_xen, 1'b0);
    chk($sformatf("%s done x", tag), o_x, 1'b0);
    chk($sformatf("%s done ready", tag), o_rdy, 1'b1);
  endtask

  initial begin
    int r;
    int ab;
    logic [W-1:0] d;
    clr = 1'b1; iv_a = 1'b0; iv_b = 1'b0; din = '0; drep = '0; abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset x", x_a, 1'b0);
    chk("reset x_en", xen_a, 1'b0);
    chk("reset busy", busy_a, 1'b0);
    chk("reset done", done_a, 1'b0);
    chk("reset ready", bus_a.in_ready, 1'b1);
    chk("reset busy b", busy_b, 1'b0);
    clr = 1'b0;
    step();

    xfer(1'b0, 8'b1011_0010, 4'd0, 0, 1'b0, "t1");
    idle_chk(1, "t1 post");
    xfer(1'b0, 8'hA5, 4'd2, 0, 1'b0, "t2");
    idle_chk(2, "t2 post");
    xfer(1'b0, 8'hFF, 4'd0, 4, 1'b0, "t3");
    xfer(1'b0, 8'h3C, 4'd1, 0, 1'b0, "t3 reaccept");
    idle_chk(1, "t3 post");

    // clr mid-transfer, with in_valid high, lands in the reset state
    cur_sel = 1'b0;
    iv_a = 1'b1; din = 8'h5A; drep = 4'd3;
    step();
    iv_a = 1'b0;
    repeat (5) step();
    chk("t4 busy before clr", busy_a, 1'b1);
    clr = 1'b1; iv_a = 1'b1;
    step();
    chk("t4 clr x_en", xen_a, 1'b0);
    chk("t4 clr x", x_a, 1'b0);
    chk("t4 clr busy", busy_a, 1'b0);
    chk("t4 clr done", done_a, 1'b0);
    step();
    chk("t4 clr idle accept busy", busy_a, 1'b0);
    clr = 1'b0; iv_a = 1'b0;
    idle_chk(1, "t4 post");

    xfer(1'b0, 8'h81, 4'd0, 0, 1'b1, "t5a");
    xfer(1'b0, 8'h7E, 4'd0, 0, 1'b0, "t5b");
    idle_chk(1, "t5 post");

    // abort while idle blocks acceptance
    abort = 1'b1; iv_a = 1'b1;
    #1;
    chk("idle abort ready", bus_a.in_ready, 1'b0);
    step();
    chk("idle abort busy", busy_a, 1'b0);
    abort = 1'b0; iv_a = 1'b0;
    step();

    xfer(1'b1, 8'hC3, 4'd1, 0, 1'b0, "t6");
    idle_chk(1, "t6 post");
    xfer(1'b0, 8'h96, 4'd15, 0, 1'b0, "rep15");
    idle_chk(1, "rep15 post");

    for (int t = 0; t < 24; t++) begin
      bit s;
      s  = 1'($urandom_range(0, 1));
      d  = W'($urandom);
      r  = $urandom_range(0, 3);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, (r + 1) * (W + (s ? 0 : 2))) : 0;
      xfer(s, d, R'(r), ab, 1'b0, $sformatf("rnd%0d", t));
      if ($urandom_range(0, 1) == 1) idle_chk($urandom_range(1, 2), $sformatf("rnd%0d", t));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
